multiplier_unsigned_iter: RTL and testbench
===========================================

Name: multiplier_unsigned_iter

Overview:
Iterative radix-2 shift-add unsigned multiplier. It is the inverse-operation companion to the team's combinational unsigned divider, and feeds the same M-extension datapath for MUL/MULHU. It accepts one operand pair through a valid/ready handshake and computes for WIDTH cycles. It then holds the 2*WIDTH-bit product under a valid/ready output handshake until the consumer takes it.

Parameters:
WIDTH, 32, operand width in bits; product is 2*WIDTH bits.

Ports:
clk  input  1  clock; all state updates on the rising edge.
rst  input  1  asynchronous, active-high reset.
i_in_valid  input  1  operand pair presented.
o_in_ready  output  1  block can accept operands; high only in IDLE.
i_multiplicand  input  WIDTH  operand A, sampled on the input handshake.
i_multiplier  input  WIDTH  operand B, sampled on the input handshake.
o_out_valid  output  1  product available; high only in DONE.
i_out_ready  input  1  consumer accepts product.
o_product_lo  output  WIDTH  product bits [WIDTH-1:0] (MUL).
o_product_hi  output  WIDTH  product bits [2*WIDTH-1:WIDTH] (MULHU).
o_busy  output  1  high in BUSY or DONE.

Behaviour:
- Reset (asynchronous, active-high):
  - state=IDLE, product register=0, operand registers=0, counter=0.
  - o_out_valid=0, o_busy=0, o_in_ready=1 once rst deasserts.
  - o_product_lo/o_product_hi read 0.
- States:
  - IDLE: o_in_ready=1. On i_in_valid&&o_in_ready at an edge:
    - latch multiplicand into mcand register (zero-extended to 2*WIDTH);
    - latch multiplier into mplier register;
    - clear product; counter=0; go to BUSY.
  - BUSY: each cycle:
    - if mplier[0], product += mcand (2*WIDTH-bit add, no overflow possible);
    - mcand <<= 1; mplier >>= 1; counter++.
    - After the WIDTH-th iteration (counter==WIDTH-1 at the edge), go to DONE.
  - DONE: o_out_valid=1; product outputs stable. On i_out_ready at an edge, go to IDLE.
- No early termination: BUSY always lasts exactly WIDTH cycles.
- Latency: input handshake at edge N gives o_out_valid=1 in the cycle after edge N+WIDTH (33 cycles for WIDTH=32).
- Throughput: one result per WIDTH+2 cycles minimum. A new input cannot be accepted in the same cycle as the output handshake; o_in_ready rises the cycle after.
- i_in_valid is ignored in BUSY and DONE; operand inputs are don't-care outside the handshake cycle.
- Backpressure: while o_out_valid=1 and i_out_ready=0, the product outputs hold indefinitely.
- Product outputs:
  - Registered; they reflect the product register in every state.
  - Only guaranteed meaningful while o_out_valid=1.
  - They retain the last result in IDLE until the next accept clears the register.
- Reset mid-operation (BUSY or DONE) aborts immediately: IDLE, no o_out_valid pulse, product cleared.
- Arithmetic: result == i_multiplicand * i_multiplier exactly, unsigned, 2*WIDTH bits, for all inputs including 0 and all-ones.
- Counter width: $clog2(WIDTH) bits.

Decomposition:
- Shared package: state enum (IDLE, BUSY, DONE), WIDTH default constant, PRODUCT_WIDTH = 2*WIDTH.
- One combinational sub-module, mul_one_iter:
  - inputs: product, mcand, mplier;
  - outputs: next product, shifted mcand, shifted mplier.
  - Instantiated once and used every BUSY cycle. This is the structural mirror of the divider's one-iteration cell.

Test Plan:
1. Basic: A=7, B=6, i_out_ready=1 → o_out_valid rises exactly 33 cycles after accept; lo=42, hi=0; o_in_ready=1 the following cycle.
2. Max operands: A=B=0xFFFFFFFF → hi=0xFFFFFFFE, lo=0x00000001. Also A=0x80000000, B=2 → hi=1, lo=0.
3. Zero: A=0, B=0xDEADBEEF and A=0x12345678, B=0 → product 0; latency still 33 cycles.
4. Backpressure and busy-ignore:
   - hold i_out_ready=0 for 10 cycles after o_out_valid → outputs and o_out_valid stable;
   - pulse i_in_valid during BUSY with other operands → ignored, result unchanged.
5. Reset mid-op: assert rst 15 cycles into BUSY → o_busy=0 and outputs 0 immediately; o_out_valid never pulses; next op A=3, B=5 → 15 after 33 cycles.
6. Random: 1000 back-to-back random pairs with random i_out_ready stalls → every product matches the 64-bit reference model, in order, none dropped or duplicated.

Source files
------------

// File: rtl/multiplier_unsigned_iter_pkg.sv
// multiplier_unsigned_iter_pkg: shared state encoding and default sizes for the iterative multiplier
package multiplier_unsigned_iter_pkg;
    localparam int WIDTH = 32;
    localparam int PRODUCT_WIDTH = 2 * WIDTH;
    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
endpackage

// File: rtl/multiplier_unsigned_iter_if.sv
// multiplier_unsigned_iter_if: operand/product handshake bundle between a requester and the multiplier
interface multiplier_unsigned_iter_if
    import multiplier_unsigned_iter_pkg::*;
#(
    parameter int W = WIDTH
);
    logic         i_in_valid;
    logic         o_in_ready;
    logic [W-1:0] i_multiplicand;
    logic [W-1:0] i_multiplier;
    logic         o_out_valid;
    logic         i_out_ready;
    logic [W-1:0] o_product_lo;
    logic [W-1:0] o_product_hi;
    logic         o_busy;
    modport slave (
        input  i_in_valid, i_multiplicand, i_multiplier, i_out_ready,
        output o_in_ready, o_out_valid, o_product_lo, o_product_hi, o_busy
    );
    modport master (
        output i_in_valid, i_multiplicand, i_multiplier, i_out_ready,
        input  o_in_ready, o_out_valid, o_product_lo, o_product_hi, o_busy
    );
endinterface

// File: rtl/multiplier_unsigned_iter_mul_one_iter.sv
// mul_one_iter: one shift-add step, conditionally accumulating the shifted multiplicand
module mul_one_iter
    import multiplier_unsigned_iter_pkg::*;
#(
    parameter int W = WIDTH
) (
    input  logic [2*W-1:0] product,
    input  logic [2*W-1:0] mcand,
    input  logic [W-1:0]   mplier,
    output logic [2*W-1:0] next_product,
    output logic [2*W-1:0] next_mcand,
    output logic [W-1:0]   next_mplier
);
    assign next_product = mplier[0] ? product + mcand : product;
    assign next_mcand   = mcand << 1;
    assign next_mplier  = mplier >> 1;
endmodule

// File: rtl/multiplier_unsigned_iter.sv
// multiplier_unsigned_iter: radix-2 shift-add unsigned multiplier, W cycles per product
module multiplier_unsigned_iter
    import multiplier_unsigned_iter_pkg::*;
#(
    parameter int W = WIDTH
) (
    input logic clk,
    input logic rst,
    multiplier_unsigned_iter_if.slave bus
);
    localparam int CW = $clog2(W);
    state_t         state;
    logic [2*W-1:0] product, mcand, next_product, next_mcand;
    logic [W-1:0]   mplier, next_mplier;
    logic [CW-1:0]  cnt;
    logic           in_ready, out_valid, busy;
    mul_one_iter #(.W(W)) u_iter (
        .product(product),
        .mcand(mcand),
        .mplier(mplier),
        .next_product(next_product),
        .next_mcand(next_mcand),
        .next_mplier(next_mplier)
    );
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            product   <= '0;
            mcand     <= '0;
            mplier    <= '0;
            cnt       <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            case (state)
                IDLE: if (bus.i_in_valid) begin
                    mcand    <= {{W{1'b0}}, bus.i_multiplicand};
                    mplier   <= bus.i_multiplier;
                    product  <= '0;
                    cnt      <= '0;
                    in_ready <= 1'b0;
                    busy     <= 1'b1;
                    state    <= BUSY;
                end
                BUSY: begin
                    product <= next_product;
                    mcand   <= next_mcand;
                    mplier  <= next_mplier;
                    cnt     <= cnt + 1'b1;
                    // last of exactly W iterations; no early exit on a zero multiplier
                    if (cnt == CW'(W - 1)) begin
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: if (bus.i_out_ready) begin
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                    in_ready  <= 1'b1;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
    assign bus.o_in_ready   = in_ready;
    assign bus.o_out_valid  = out_valid;
    assign bus.o_busy       = busy;
    assign bus.o_product_lo = product[W-1:0];
    assign bus.o_product_hi = product[2*W-1:W];
endmodule

// File: tb/tb_multiplier_unsigned_iter.sv
// tb_multiplier_unsigned_iter: transaction-level reference model plus directed and random operand traffic
module tb_multiplier_unsigned_iter;
    localparam int W = 32;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int tests = 0;
    int fails = 0;
    multiplier_unsigned_iter_if #(.W(W)) bus();
    multiplier_unsigned_iter #(.W(W)) dut (.clk(clk), .rst(rst), .bus(bus));
    always #5 clk = ~clk;

    // Reference: one outstanding op, result appears W edges after accept, held until taken.
    logic        m_busy = 1'b0;
    int          m_cnt = 0;
    int          m_done = 0;
    logic [63:0] m_exp = '0;
    logic [63:0] m_last = '0;
    wire         m_valid = m_busy && (m_cnt == W);
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_busy <= 1'b0;
            m_cnt  <= 0;
            m_last <= '0;
        end else if (!m_busy) begin
            if (bus.i_in_valid) begin
                m_busy <= 1'b1;
                m_cnt  <= 0;
                m_exp  <= {32'b0, bus.i_multiplicand} * {32'b0, bus.i_multiplier};
            end
        end else if (m_cnt == W) begin
            if (bus.i_out_ready) begin
                m_busy <= 1'b0;
                m_last <= m_exp;
                m_done <= m_done + 1;
            end
        end else begin
            m_cnt <= m_cnt + 1;
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (rst) begin
            chk("rst_out_valid", 64'(bus.o_out_valid), 64'd0);
            chk("rst_busy", 64'(bus.o_busy), 64'd0);
            chk("rst_product", {bus.o_product_hi, bus.o_product_lo}, 64'd0);
        end else begin
            chk("in_ready", 64'(bus.o_in_ready), 64'(!m_busy));
            chk("busy", 64'(bus.o_busy), 64'(m_busy));
            chk("out_valid", 64'(bus.o_out_valid), 64'(m_valid));
            if (m_valid)
                chk("product", {bus.o_product_hi, bus.o_product_lo}, m_exp);
            else if (!m_busy)
                chk("idle_product", {bus.o_product_hi, bus.o_product_lo}, m_last);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input int stall,
                          input bit poke, input logic [31:0] hi, input logic [31:0] lo);
        int n = 0;
        chk("literal_vs_arith", {32'b0, a} * {32'b0, b}, {hi, lo});
        bus.i_in_valid = 1'b1;
        bus.i_multiplicand = a;
        bus.i_multiplier = b;
        bus.i_out_ready = 1'b0;
        step();
        bus.i_in_valid = 1'b0;
        bus.i_multiplicand = 32'hA5A5_5A5A;
        bus.i_multiplier = 32'h0F0F_F0F0;
        while (!bus.o_out_valid && n < 100) begin
            bus.i_in_valid = poke && (n == 5);
            step();
            n++;
        end
        bus.i_in_valid = 1'b0;
        chk("latency", 64'(n), 64'(W));
        repeat (stall) step();
        chk("held_valid", 64'(bus.o_out_valid), 64'd1);
        chk("result", {bus.o_product_hi, bus.o_product_lo}, {hi, lo});
        bus.i_out_ready = 1'b1;
        step();
        bus.i_out_ready = 1'b0;
        chk("ready_after", 64'(bus.o_in_ready), 64'd1);
        chk("valid_after", 64'(bus.o_out_valid), 64'd0);
    endtask

    initial begin
        int cyc = 0;
        int start;
        bus.i_in_valid = 1'b0;
        bus.i_multiplicand = '0;
        bus.i_multiplier = '0;
        bus.i_out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        step();
        chk("reset_in_ready", 64'(bus.o_in_ready), 64'd1);
        run_op(32'd7, 32'd6, 0, 1'b0, 32'd0, 32'd42);
        run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 1'b0, 32'hFFFF_FFFE, 32'h0000_0001);
        run_op(32'h8000_0000, 32'd2, 0, 1'b0, 32'd1, 32'd0);
        run_op(32'd0, 32'hDEAD_BEEF, 0, 1'b0, 32'd0, 32'd0);
        run_op(32'h1234_5678, 32'd0, 0, 1'b0, 32'd0, 32'd0);
        run_op(32'd1000, 32'd1000, 10, 1'b1, 32'd0, 32'd1_000_000);
        // abort partway through an operation
        bus.i_in_valid = 1'b1;
        bus.i_multiplicand = 32'h1234_5678;
        bus.i_multiplier = 32'h9ABC_DEF0;
        step();
        bus.i_in_valid = 1'b0;
        repeat (15) step();
        rst = 1'b1;
        #1;
        chk("abort_busy", 64'(bus.o_busy), 64'd0);
        chk("abort_valid", 64'(bus.o_out_valid), 64'd0);
        chk("abort_product", {bus.o_product_hi, bus.o_product_lo}, 64'd0);
        step();
        rst = 1'b0;
        step();
        run_op(32'd3, 32'd5, 0, 1'b0, 32'd0, 32'd15);
        // back-to-back random traffic with random consumer stalls
        start = m_done;
        bus.i_in_valid = 1'b1;
        while (m_done - start < 1000 && cyc < 60000) begin
            case ($urandom_range(0, 7))
                0: bus.i_multiplicand = '0;
                1: bus.i_multiplicand = '1;
                default: bus.i_multiplicand = $urandom;
            endcase
            bus.i_multiplier = ($urandom_range(0, 7) == 0) ? '1 : $urandom;
            bus.i_out_ready = $urandom_range(0, 3) != 0;
            step();
            cyc++;
        end
        bus.i_in_valid = 1'b0;
        bus.i_out_ready = 1'b1;
        cyc = 0;
        while (m_busy && cyc < 200) begin
            step();
            cyc++;
        end
        chk("random_count", 64'(m_done - start >= 1000), 64'd1);
        chk("drained", 64'(bus.o_busy), 64'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
